// File: rtl/aes_op_sched.sv
// Sequencer in front of the AES encrypt/decrypt cores. It takes one job at a time,
// caches the last expanded decrypt key and turns a hung core into an error response.
module aes_op_sched #(
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [DATA_W-1:0] req_key,
  input  logic [DATA_W-1:0] req_text,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_text,
  output logic              rsp_mode,
  output logic              rsp_err,
  output logic              core_mode,
  output logic              core_ld,
  output logic              core_kld,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_text_in,
  input  logic              core_done,
  input  logic              core_kdone,
  input  logic [DATA_W-1:0] core_text_out,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KLD, S_KWAIT, S_LOAD, S_RUN, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                core_mode_q, core_mode_d;
  logic [DATA_W-1:0]   core_key_q, core_key_d;
  logic [DATA_W-1:0]   core_text_q, core_text_d;
  logic [DATA_W-1:0]   rsp_text_q, rsp_text_d;
  logic                rsp_mode_q, rsp_mode_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   kc_key_q, kc_key_d;
  logic                kc_valid_q, kc_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      core_mode_q <= 1'b0;
      core_key_q  <= '0;
      core_text_q <= '0;
      rsp_text_q  <= '0;
      rsp_mode_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      kc_key_q    <= '0;
      kc_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_mode_q <= core_mode_d;
      core_key_q  <= core_key_d;
      core_text_q <= core_text_d;
      rsp_text_q  <= rsp_text_d;
      rsp_mode_q  <= rsp_mode_d;
      rsp_err_q   <= rsp_err_d;
      kc_key_q    <= kc_key_d;
      kc_valid_q  <= kc_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_mode_d = core_mode_q;
    core_key_d  = core_key_q;
    core_text_d = core_text_q;
    rsp_text_d  = rsp_text_q;
    rsp_mode_d  = rsp_mode_q;
    rsp_err_d   = rsp_err_q;
    kc_key_d    = kc_key_q;
    kc_valid_d  = kc_valid_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          core_mode_d = req_mode;
          core_key_d  = req_key;
          core_text_d = req_text;
          // Only a decrypt whose key differs from the cached expansion needs kld.
          if (req_mode && (!kc_valid_q || (req_key != kc_key_q))) state_d = S_KLD;
          else                                                    state_d = S_LOAD;
        end
      end
      S_KLD: begin
        cnt_d   = '0;
        state_d = S_KWAIT;
      end
      S_KWAIT: begin
        if (core_kdone) begin
          kc_key_d   = core_key_q;
          kc_valid_d = 1'b1;
          state_d    = S_LOAD;
        end else if (cnt_q == CNT_LAST) begin
          rsp_text_d = '0;
          rsp_mode_d = core_mode_q;
          rsp_err_d  = 1'b1;
          kc_valid_d = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done is checked before the watchdog so a coincident done still succeeds.
        if (core_done) begin
          rsp_text_d = core_text_out;
          rsp_mode_d = core_mode_q;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_text_d = '0;
          rsp_mode_d = core_mode_q;
          rsp_err_d  = 1'b1;
          kc_valid_d = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign core_kld     = (state_q == S_KLD);
  assign core_ld      = (state_q == S_LOAD);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_text     = rsp_text_q;
  assign rsp_mode     = rsp_mode_q;
  assign rsp_err      = rsp_err_q;
  assign core_mode    = core_mode_q;
  assign core_key     = core_key_q;
  assign core_text_in = core_text_q;

endmodule

// File: tb/tb_aes_op_sched.sv
// Bench for aes_op_sched: stub cores with programmable latencies, a job-level reference
// model (key cache, watchdog, latency) and randomized jobs.
module tb_aes_op_sched;
  localparam int W  = 128;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_mode = 1'b0;
  logic [W-1:0] req_key = '0, req_text = '0;
  logic rsp_ready = 1'b0, core_done = 1'b0, core_kdone = 1'b0;
  logic req_ready, rsp_valid, rsp_mode, rsp_err, core_mode, core_ld, core_kld, busy;
  logic [W-1:0] rsp_text, core_key, core_text_in, core_text_out;

  int checks = 0;
  int failures = 0;
  logic         exp_kc_valid = 1'b0;
  logic [W-1:0] exp_kc_key = '0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  aes_op_sched #(.TIMEOUT(TO), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text),
    .rsp_mode(rsp_mode), .rsp_err(rsp_err),
    .core_mode(core_mode), .core_ld(core_ld), .core_kld(core_kld),
    .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_kdone(core_kdone), .core_text_out(core_text_out),
    .busy(busy)
  );

  // Stand-in for the cipher cores: a cheap keyed transform, distinct per mode.
  function automatic logic [W-1:0] core_fn(input logic m, input logic [W-1:0] k, input logic [W-1:0] t);
    return m ? (t ^ k ^ {W{1'b1}}) : ({t[63:0], t[127:64]} ^ k);
  endfunction

  assign core_text_out = core_fn(core_mode, core_key, core_text_in);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // A job runs to its response; klat/rlat are cycles from the kld/ld pulse to kdone/done
  // (0 = the core never answers), bp is the number of cycles rsp_ready is held low.
  task automatic run_job(input logic m, input logic [W-1:0] k, input logic [W-1:0] t,
                         input int klat, input int rlat, input int bp, input logic spur);
    bit miss, kfail, rfail, stable_bad, rsp_bad, seen;
    int exp_lat, exp_klds, exp_lds, klds, lds, kld_at, ld_at, a, i;
    logic [W-1:0] exp_text;
    miss    = m && (!exp_kc_valid || k != exp_kc_key);
    kfail   = miss && (klat < 1 || klat > TO);
    rfail   = !kfail && (rlat < 1 || rlat > TO);
    exp_klds = miss ? 1 : 0;
    exp_lds  = kfail ? 0 : 1;
    if (kfail)     exp_lat = TO + 2;
    else           exp_lat = (miss ? klat + 1 : 0) + (rfail ? TO + 2 : rlat + 2);
    exp_text = (kfail || rfail) ? '0 : core_fn(m, k, t);
    if (kfail || rfail) exp_kc_valid = 1'b0;
    else if (miss) begin exp_kc_valid = 1'b1; exp_kc_key = k; end
    exp_q.push_back(exp_text);

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_mode = m; req_key = k; req_text = t;
    a = 0; klds = 0; lds = 0; kld_at = -1; ld_at = -1; stable_bad = 0; seen = 0;
    for (i = 1; i < 60; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      core_kdone = 1'b0; core_done = 1'b0;
      if (core_mode !== m || core_key !== k || core_text_in !== t) stable_bad = 1;
      if (rsp_valid) begin seen = 1; break; end
      if (core_kld) begin klds++; kld_at = i; end
      if (core_ld)  begin lds++;  ld_at = i; core_done = spur; end
      if (kld_at >= 0 && klat > 0 && i == kld_at + klat) core_kdone = 1'b1;
      if (ld_at >= 0 && rlat > 0 && i == ld_at + rlat)   core_done = 1'b1;
    end
    core_kdone = 1'b0; core_done = 1'b0;
    chk("rsp_seen", seen, 1);
    chk("latency", i - a, exp_lat);
    chk("kld_pulses", klds, exp_klds);
    chk("ld_pulses", lds, exp_lds);
    chk("rsp_text", rsp_text, exp_q.pop_front());
    chk("rsp_mode", rsp_mode, m);
    chk("rsp_err", rsp_err, kfail || rfail);
    // A competing request is held during backpressure and must not be taken.
    rsp_bad = 0;
    req_valid = 1'b1; req_mode = ~m; req_key = ~k; req_text = ~t;
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_text !== exp_text || rsp_mode !== m ||
          rsp_err !== (kfail || rfail)) rsp_bad = 1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("rsp_hold", rsp_bad, 0);
    chk("core_ops_stable", stable_bad || core_key !== k || core_mode !== m, 0);
    chk("rsp_valid_drop", {rsp_valid, req_ready, busy}, 3'b010);
    chk("rsp_text_hold", rsp_text, exp_text);
  endtask

  // Starts a job whose core never answers, then resets inside KWAIT (decrypt miss) or RUN.
  task automatic abort_job(input logic m, input logic [W-1:0] k);
    int n;
    bit hit;
    @(negedge clk);
    req_valid = 1'b1; req_mode = m; req_key = k; req_text = k ^ 128'h5a;
    @(negedge clk);
    req_valid = 1'b0;
    hit = 0;
    for (n = 0; n < 20; n++) begin
      if (m ? core_kld : core_ld) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("abort_pulse", hit, 1);
    @(negedge clk); @(negedge clk);
    chk("abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_flags", {busy, core_ld, core_kld, rsp_valid, rsp_err, rsp_mode, core_mode, req_ready}, 8'h01);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_text", core_text_in, 0);
    chk("rst_rsp_text", rsp_text, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_kc_valid = 1'b0;
    hit = 0;
    for (n = 0; n < 5; n++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) hit = 1;
    end
    chk("no_rsp_after_rst", hit, 0);
  endtask

  localparam logic [W-1:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [W-1:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [W-1:0] KF = {W{1'b1}};

  initial begin
    logic [W-1:0] pool [3];
    pool[0] = K1; pool[1] = KF; pool[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    #1;
    chk("reset_flags", {busy, core_ld, core_kld, rsp_valid, rsp_err, rsp_mode, core_mode, req_ready}, 8'h01);
    chk("reset_rsp_text", rsp_text, 0);
    @(negedge clk);
    rst = 1'b0;

    run_job(0, K1, P1, 0, 3, 0, 0);   // encrypt
    run_job(1, K1, C1, 4, 5, 0, 0);   // decrypt, cold cache
    run_job(1, K1, C1, 4, 3, 0, 0);   // decrypt hit, encrypt latency
    run_job(1, KF, C1, 2, 4, 1, 0);   // key change -> miss
    run_job(0, K1, P1, 0, 2, 0, 0);   // interleaved encrypt
    run_job(1, KF, P1, 3, 2, 0, 0);   // still a hit
    run_job(0, K1, P1, 0, 0, 0, 0);   // hung core -> error, cache dropped
    run_job(1, KF, C1, 2, 2, 0, 0);   // miss after error
    run_job(0, K1, P1, 0, TO, 0, 0);  // done on the last watchdog cycle
    run_job(1, K1, C1, 0, 2, 0, 0);   // key expansion hangs
    run_job(1, K1, C1, TO, 1, 0, 0);  // kdone on the last watchdog cycle
    run_job(0, KF, P1, 0, 4, 5, 1);   // backpressure + spurious done in LOAD
    abort_job(0, K1);                 // reset mid-RUN
    run_job(1, K1, C1, 2, 2, 0, 0);   // cache was cleared by reset
    abort_job(1, KF);                 // reset mid-KWAIT
    run_job(1, K1, C1, 1, 3, 0, 0);

    for (int r = 0; r < 40; r++) begin
      run_job(1'($urandom_range(0, 1)), pool[$urandom_range(0, 2)],
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 10), $urandom_range(0, 10),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
